mult_share_arbiter: RTL and testbench

- Shares one 4x4 pipelined array multiplier (5-stage, en tied high, result on p exactly MUL_LAT clocks after operands are applied) among NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per clock into the multiplier.
- A valid/ID tag pipeline tracks each operation through the multiplier so the 8-bit product is returned to the requester that issued it.
- Sits between requester blocks and the multiplier instance.

---
 rtl/mult_share_arbiter_pkg.sv | 17 +
 rtl/mult_share_arbiter_rr_arbiter.sv | 48 ++++
 rtl/mult_share_arbiter.sv | 117 +++++++++++
 tb/tb_mult_share_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and tag type for the multiplier-sharing arbiter.
// The tag travels alongside each operation through the external multiplier.
package mult_share_arbiter_pkg;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned OP_W      = 4;
    localparam int unsigned MUL_LAT   = 5;
    localparam int unsigned TAG_DEPTH = MUL_LAT + 1;
    localparam int unsigned CNT_W     = 4;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin grant selection with a registered pointer.
// The search starts at the pointer and wraps; gnt is combinational.
module mult_share_arbiter_rr_arbiter
    import mult_share_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic [NUM_REQ-1:0] req_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_id_o,
    output logic               gnt_valid_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        logic            found;
        logic [ID_W-1:0] sel;
        found       = 1'b0;
        sel         = '0;
        gnt_o       = '0;
        gnt_id_o    = '0;
        gnt_valid_o = 1'b0;
        ptr_d       = ptr_q;
        if (!hold_i && !rst_i) begin
            for (int unsigned off = 0; off < NUM_REQ; off++) begin
                sel = ID_W'((32'(ptr_q) + off) % NUM_REQ);
                if (!found && req_i[sel]) begin
                    found          = 1'b1;
                    gnt_o[sel]     = 1'b1;
                    gnt_id_o       = sel;
                    gnt_valid_o    = 1'b1;
                    ptr_d          = ID_W'((32'(sel) + 1) % NUM_REQ);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one pipelined multiplier among NUM_REQ requesters; a tag pipeline
// aligned with the multiplier latency routes each product back to its issuer.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*OP_W-1:0] a_in,
    input  logic [NUM_REQ*OP_W-1:0] b_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [OP_W-1:0]         mul_a,
    output logic [OP_W-1:0]         mul_b,
    input  logic [2*OP_W-1:0]       mul_p,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2*OP_W-1:0]       rsp_p,
    output logic [ID_W-1:0]         rsp_id,
    output logic [CNT_W-1:0]        inflight,
    output logic                    idle
);

    logic [ID_W-1:0]    gnt_id;
    logic               gnt_valid;
    logic [OP_W-1:0]    issue_a, issue_b;
    tag_t               issue_tag;
    tag_t               tag_q [TAG_DEPTH];
    tag_t               ret_tag;
    logic [NUM_REQ-1:0] ret_onehot;

    logic [OP_W-1:0]    mul_a_q, mul_b_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [2*OP_W-1:0]  rsp_p_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [CNT_W-1:0]   inflight_q, inflight_d;

    mult_share_arbiter_rr_arbiter u_rr (
        .clk_i       (clk),
        .rst_i       (rst),
        .hold_i      (hold),
        .req_i       (req),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    // Idle slots push zero operands so the multiplier never sees stale data.
    always_comb begin
        issue_a         = '0;
        issue_b         = '0;
        issue_tag.valid = gnt_valid;
        issue_tag.id    = gnt_id;
        if (gnt_valid) begin
            issue_a = a_in[32'(gnt_id)*OP_W +: OP_W];
            issue_b = b_in[32'(gnt_id)*OP_W +: OP_W];
        end
    end

    assign ret_tag = tag_q[TAG_DEPTH-1];

    always_comb begin
        ret_onehot             = '0;
        ret_onehot[ret_tag.id] = 1'b1;
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({gnt_valid, ret_tag.valid})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= issue_tag;
            for (int unsigned k = 1; k < TAG_DEPTH; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            inflight_q  <= '0;
        end else begin
            mul_a_q     <= issue_a;
            mul_b_q     <= issue_b;
            inflight_q  <= inflight_d;
            rsp_valid_q <= '0;
            if (ret_tag.valid) begin
                rsp_valid_q <= ret_onehot;
                rsp_p_q     <= mul_p;
                rsp_id_q    <= ret_tag.id;
            end
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_p     = rsp_p_q;
    assign rsp_id    = rsp_id_q;
    assign inflight  = inflight_q;
    assign idle      = (inflight_q == '0) && (req == '0);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter with a queue-based
// reference model and a 5-stage multiplier model driving mul_p.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic [3:0]  req;
    logic [15:0] a_in, b_in;
    logic [3:0]  gnt;
    logic [3:0]  mul_a, mul_b;
    logic [7:0]  mul_p;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_p;
    logic [1:0]  rsp_id;
    logic [3:0]  inflight;
    logic        idle;

    mult_share_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .inflight  (inflight),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    // External multiplier: product appears on mul_p 5 edges after operands.
    logic [7:0] pipe [5];
    initial for (int k = 0; k < 5; k++) pipe[k] = 8'd0;
    always @(posedge clk) begin
        pipe[0] <= 8'(mul_a) * 8'(mul_b);
        for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
    end
    assign mul_p = pipe[4];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {int due; int id; int p;} exp_t;
    typedef struct {int id; int p;} seen_t;
    exp_t  expq [$];
    seen_t seen [$];
    int    m_ptr = 0;
    int    m_cyc = 0;
    logic [7:0] m_last_p = '0;
    logic [1:0] m_last_id = '0;
    logic [3:0] m_prev_a = '0, m_prev_b = '0;

    // Reference model: a result is due 7 cycles after its grant cycle;
    // inflight is simply the number of results still owed.
    always @(negedge clk) begin
        exp_t e;
        int   g;
        logic [3:0] eg;
        m_cyc++;
        if (rst) begin
            expq.delete();
            m_ptr = 0; m_last_p = '0; m_last_id = '0; m_prev_a = '0; m_prev_b = '0;
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_inflight", 32'(inflight), 0);
            chk("rst_rsp_p", 32'(rsp_p), 0);
            chk("rst_mul_a", 32'(mul_a), 0);
        end else begin
            if (expq.size() > 0 && expq[0].due == m_cyc) begin
                e = expq.pop_front();
                chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.id));
                chk("rsp_id", 32'(rsp_id), 32'(e.id));
                chk("rsp_p", 32'(rsp_p), 32'(e.p));
                m_last_p = 8'(e.p);
                m_last_id = 2'(e.id);
                seen.push_back('{id: int'(rsp_id), p: int'(rsp_p)});
            end else begin
                chk("rsp_quiet", 32'(rsp_valid), 0);
                chk("rsp_p_hold", 32'(rsp_p), 32'(m_last_p));
                chk("rsp_id_hold", 32'(rsp_id), 32'(m_last_id));
            end
            chk("inflight", 32'(inflight), 32'(expq.size()));
            chk("idle", 32'(idle), 32'(expq.size() == 0 && req == 4'd0));
            chk("mul_a", 32'(mul_a), 32'(m_prev_a));
            chk("mul_b", 32'(mul_b), 32'(m_prev_b));
            g = -1;
            if (!hold) begin
                for (int k = 0; k < 4; k++) begin
                    if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
                end
            end
            eg = (g < 0) ? 4'd0 : 4'(1 << g);
            chk("gnt", 32'(gnt), 32'(eg));
            if (g >= 0) begin
                m_prev_a = a_in[g*4 +: 4];
                m_prev_b = b_in[g*4 +: 4];
                expq.push_back('{due: m_cyc + 7, id: g, p: int'(m_prev_a) * int'(m_prev_b)});
                m_ptr = (g + 1) % 4;
            end else begin
                m_prev_a = '0;
                m_prev_b = '0;
            end
        end
    end

    logic [3:0] last_gnt;

    task automatic step();
        @(negedge clk);
        last_gnt = gnt;
        @(posedge clk);
        #1;
    endtask

    task automatic setop(input int i, input logic [3:0] a, input logic [3:0] b);
        a_in[i*4 +: 4] = a;
        b_in[i*4 +: 4] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; hold = 1'b0;
        step(); step();
        rst = 1'b0;
        seen.delete();
    endtask

    initial begin
        int cnt0, cnt3, errs;
        int prods [4];
        prods = '{225, 14, 9, 0};
        rst = 1'b1; hold = 1'b0; req = '0; a_in = '0; b_in = '0;
        do_reset();

        // Single request, 3*5.
        setop(0, 4'd3, 4'd5);
        req = 4'b0001;
        step();
        chk("t1_gnt", 32'(last_gnt), 32'b0001);
        req = '0;
        repeat (9) step();
        chk("t1_count", 32'(seen.size()), 1);
        if (seen.size() > 0) begin
            chk("t1_p", 32'(seen[0].p), 15);
            chk("t1_id", 32'(seen[0].id), 0);
        end
        chk("t1_inflight", 32'(inflight), 0);

        // Four requesters streaming.
        do_reset();
        setop(0, 4'd15, 4'd15); setop(1, 4'd2, 4'd7); setop(2, 4'd9, 4'd1); setop(3, 4'd0, 4'd12);
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_gnt", 32'(last_gnt), 32'(1 << (k % 4)));
        end
        req = '0;
        repeat (10) step();
        chk("t2_count", 32'(seen.size()), 8);
        for (int k = 0; k < 8 && k < seen.size(); k++) chk("t2_p", 32'(seen[k].p), 32'(prods[k % 4]));

        // Pointer wrap: grant 2 first so the pointer sits at 3.
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b1001;
        step();
        chk("t3_gnt_wrap", 32'(last_gnt), 32'b1000);
        step();
        chk("t3_gnt_next", 32'(last_gnt), 32'b0001);
        cnt0 = 0; cnt3 = 0;
        repeat (8) begin
            step();
            if (last_gnt[0]) cnt0++;
            if (last_gnt[3]) cnt3++;
        end
        chk("t3_no_starve", 32'(cnt0 >= 3 && cnt3 >= 3), 1);
        req = '0;
        repeat (10) step();

        // hold mid-stream, then drain.
        do_reset();
        req = 4'b1111;
        repeat (3) step();
        hold = 1'b1;
        repeat (3) begin
            step();
            chk("t4_hold_gnt", 32'(last_gnt), 0);
        end
        req = '0;
        repeat (8) step();
        hold = 1'b0;
        step();
        chk("t4_count", 32'(seen.size()), 3);
        chk("t4_idle", 32'(idle), 1);

        // Reset with operations in flight.
        do_reset();
        req = 4'b1111;
        repeat (4) step();
        req = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk("t5_no_rsp", 32'(seen.size()), 0);
        chk("t5_inflight", 32'(inflight), 0);
        setop(1, 4'd6, 4'd7);
        req = 4'b0010;
        step();
        chk("t5_gnt", 32'(last_gnt), 32'b0010);
        req = '0;
        repeat (9) step();
        chk("t5_count", 32'(seen.size()), 1);
        if (seen.size() > 0) begin
            chk("t5_p", 32'(seen[0].p), 42);
            chk("t5_id", 32'(seen[0].id), 1);
        end

        // Exhaustive operand sweep through requester 2.
        do_reset();
        req = 4'b0100;
        for (int k = 0; k < 256; k++) begin
            setop(2, 4'(k >> 4), 4'(k & 15));
            step();
        end
        req = '0;
        repeat (10) step();
        chk("t6_count", 32'(seen.size()), 256);
        errs = 0;
        for (int k = 0; k < seen.size(); k++) begin
            if (seen[k].p != (k >> 4) * (k & 15) || seen[k].id != 2) errs++;
        end
        chk("t6_products", 32'(errs), 0);

        // Random traffic: each request held until its handshake completes.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (req[i] && last_gnt[i]) req[i] = 1'b0;
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                    setop(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                end
            end
            hold = ($urandom_range(0, 7) == 0);
        end
        req = '0; hold = 1'b0;
        repeat (12) step();
        chk("t7_idle", 32'(idle), 1);
        chk("t7_inflight", 32'(inflight), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
